// File: rtl/fwrisc_mem_arb.sv
// rtl/fwrisc_mem_arb.sv - two-requester (fetch/data) arbiter onto one memory port
// Build option: define FWRISC_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise data requests have fixed priority over fetch.
module fwrisc_mem_arb #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ireq,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  output logic                  iack,
  output logic [31:0]           irdata,
  input  logic                  dreq,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  dwe,
  input  logic [3:0]            dwstrb,
  input  logic [31:0]           dwdata,
  output logic                  dack,
  output logic [31:0]           drdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  iack_q, iack_d;
  logic                  dack_q, dack_d;
  logic [31:0]           irdata_q, irdata_d;
  logic [31:0]           drdata_q, drdata_d;
  logic                  pick_d;

`ifdef FWRISC_MEM_ARB_RR_EN
  logic                  last_q, last_d;

  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    if (dreq && ireq) pick_d = ~last_q;
    else              pick_d = dreq;
  end
`else
  // Fixed priority: any data request beats a fetch.
  always_comb begin
    pick_d = dreq;
  end
`endif

  // Next-state: latch winner payload in IDLE, wait for memory in BUSY, pulse ack in RESP.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
`ifdef FWRISC_MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dreq || ireq) begin
          gnt_d     = pick_d;
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
`ifdef FWRISC_MEM_ARB_RR_EN
          last_d    = pick_d;
`endif
          if (pick_d) begin
            mem_addr_d  = daddr;
            mem_we_d    = dwe;
            mem_wstrb_d = dwe ? dwstrb : 4'b0000;
            mem_wdata_d = dwdata;
          end else begin
            // Fetches are always plain reads.
            mem_addr_d  = iaddr;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'b0000;
            mem_wdata_d = 32'h0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (gnt_q) begin
            drdata_d = mem_rdata;
            dack_d   = 1'b1;
          end else begin
            irdata_d = mem_rdata;
            iack_d   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        // Ack is visible this cycle; requests are not looked at until IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      irdata_q    <= 32'h0;
      drdata_q    <= 32'h0;
`ifdef FWRISC_MEM_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
`ifdef FWRISC_MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign iack      = iack_q;
  assign dack      = dack_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;

endmodule
